// File: rtl/disp_pkg.sv
// Shared types and constants for the display time selector and its divider.
// The divider turns a seconds count into minutes and seconds.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DIV  = 2'd2
  } disp_state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int SEC_W       = 6;

endpackage

// File: rtl/sec_to_minsec.sv
// Iterative seconds -> minutes:seconds divider: one subtraction of 60 per step.
// The quotient saturates at all-ones, and sat tells the owner to stop.
module sec_to_minsec
  import disp_pkg::*;
#(
  parameter int W     = 12,
  parameter int MIN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     load_val,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] quo,
  output logic             done,
  output logic             sat
);

  logic [W-1:0]     rem_reg;
  logic [MIN_W-1:0] quo_reg;

  assign done = int'(rem_reg) < SEC_PER_MIN;
  assign sat  = !done && (quo_reg == {MIN_W{1'b1}});
  assign sec  = rem_reg[SEC_W-1:0];
  assign quo  = quo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
    end else if (load) begin
      rem_reg <= load_val;
      quo_reg <= '0;
    end else if (step && !done && !sat) begin
      rem_reg <= rem_reg - W'(SEC_PER_MIN);
      quo_reg <= quo_reg + MIN_W'(1);
    end
  end

endmodule

// File: rtl/disp_time_sel.sv
// Display source selector: samples one of NCH time channels on start. Seconds
// channels are converted to {minutes, seconds}; the result is held until the next one.
module disp_time_sel
  import disp_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               W         = 12,
  parameter int               MIN_W     = 7,
  parameter logic [NCH-1:0]   CONV_MASK = 4'b1000,
  localparam int              SEL_W     = $clog2(NCH) + 1,
  localparam int              OUT_W     = MIN_W + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH*W-1:0]   ch_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  output logic [OUT_W-1:0]   disp_out,
  output logic               overflow
);

  disp_state_t      state_reg, state_next;
  logic [OUT_W-1:0] disp_reg, disp_next;
  logic [OUT_W-1:0] pass_reg, pass_next;
  logic             ovf_reg, ovf_next;
  logic             valid_reg, valid_next;

  logic [W-1:0]     chan [NCH];
  logic [W-1:0]     sel_val;
  logic             sel_conv;
  logic             sel_blank;
  logic [OUT_W-1:0] sel_ext;

  logic             div_load, div_step, div_done, div_sat;
  logic [SEC_W-1:0] div_sec;
  logic [MIN_W-1:0] div_quo;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign chan[gi] = ch_data[gi*W +: W];
  end

  always_comb begin
    sel_val  = '0;
    sel_conv = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(sel) == i) begin
        sel_val  = chan[i];
        sel_conv = CONV_MASK[i];
      end
    end
  end

  assign sel_blank = int'(sel) >= NCH;

  // Raw channels pass through zero-extended or truncated to the display width.
  if (W >= OUT_W) begin : g_trunc
    assign sel_ext = sel_val[OUT_W-1:0];
  end else begin : g_zext
    assign sel_ext = {{(OUT_W-W){1'b0}}, sel_val};
  end

  sec_to_minsec #(
    .W     (W),
    .MIN_W (MIN_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .load_val (sel_val),
    .sec      (div_sec),
    .quo      (div_quo),
    .done     (div_done),
    .sat      (div_sat)
  );

  always_comb begin
    state_next = state_reg;
    disp_next  = disp_reg;
    pass_next  = pass_reg;
    ovf_next   = ovf_reg;
    valid_next = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (sel_blank || !sel_conv) begin
            pass_next  = sel_blank ? '0 : sel_ext;
            state_next = PASS;
          end else begin
            div_load   = 1'b1;
            state_next = DIV;
          end
        end
      end
      PASS: begin
        disp_next  = pass_reg;
        ovf_next   = 1'b0;
        valid_next = 1'b1;
        state_next = IDLE;
      end
      DIV: begin
        // Saturation wins over done: the remainder is still >= 60 there.
        if (div_sat) begin
          disp_next  = {{MIN_W{1'b1}}, SEC_W'(SEC_PER_MIN - 1)};
          ovf_next   = 1'b1;
          valid_next = 1'b1;
          state_next = IDLE;
        end else if (div_done) begin
          disp_next  = {div_quo, div_sec};
          ovf_next   = 1'b0;
          valid_next = 1'b1;
          state_next = IDLE;
        end else begin
          div_step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      disp_reg  <= '0;
      pass_reg  <= '0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      disp_reg  <= disp_next;
      pass_reg  <= pass_next;
      ovf_reg   <= ovf_next;
      valid_reg <= valid_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = valid_reg;
  assign disp_out  = disp_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_disp_time_sel.sv
// Randomised bench for disp_time_sel. It drives two instances, with MIN_W=7 and MIN_W=6.
// Results are compared against an arithmetic divide/modulo reference model.
module tb_disp_time_sel;

  localparam int NCH   = 4;
  localparam int W     = 12;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NCH*W-1:0] a_ch, b_ch;
  logic [SEL_W-1:0] a_sel, b_sel;
  logic             a_start, b_start;
  logic             a_busy, a_valid, a_ovf;
  logic             b_busy, b_valid, b_ovf;
  logic [12:0]      a_out;
  logic [11:0]      b_out;

  disp_time_sel #(.NCH(4), .W(12), .MIN_W(7), .CONV_MASK(4'b1000)) dut_a (
    .clk(clk), .rst(rst), .ch_data(a_ch), .sel(a_sel), .start(a_start),
    .busy(a_busy), .out_valid(a_valid), .disp_out(a_out), .overflow(a_ovf)
  );

  disp_time_sel #(.NCH(4), .W(12), .MIN_W(6), .CONV_MASK(4'b1000)) dut_b (
    .clk(clk), .rst(rst), .ch_data(b_ch), .sel(b_sel), .start(b_start),
    .busy(b_busy), .out_valid(b_valid), .disp_out(b_out), .overflow(b_ovf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic dut_valid(input int d);
    return (d == 0) ? a_valid : b_valid;
  endfunction
  function automatic logic dut_busy(input int d);
    return (d == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic dut_ovf(input int d);
    return (d == 0) ? a_ovf : b_ovf;
  endfunction
  function automatic logic [31:0] dut_out(input int d);
    return (d == 0) ? 32'(a_out) : 32'(b_out);
  endfunction

  task automatic drive(input int d, input logic st, input logic [2:0] s, input logic [47:0] data);
    if (d == 0) begin
      a_start = st; a_sel = s; a_ch = data;
    end else begin
      b_start = st; b_sel = s; b_ch = data;
    end
  endtask

  // Reference: channel 3 is seconds; minutes saturate at 2^MIN_W-1 with 59 s.
  task automatic model(input int d, input logic [2:0] s, input logic [47:0] data,
                       output logic [31:0] res, output logic ovf, output int lat);
    int minw, maxq, outw, v, q;
    minw = (d == 0) ? 7 : 6;
    maxq = (1 << minw) - 1;
    outw = minw + 6;
    ovf  = 1'b0;
    if (int'(s) >= NCH) begin
      res = 0;
      lat = 1;
    end else begin
      v = int'((data >> (int'(s) * W)) & 48'hFFF);
      if (s != 3'd3) begin
        res = 32'(v & ((1 << outw) - 1));
        lat = 1;
      end else begin
        q = v / 60;
        if (q > maxq) begin
          res = 32'((maxq << 6) | 59);
          ovf = 1'b1;
          lat = maxq + 1;
        end else begin
          res = 32'((q << 6) | (v % 60));
          lat = q + 1;
        end
      end
    end
  endtask

  task automatic txn(input int d, input logic [2:0] s, input logic [47:0] data,
                     input bit noise, input string tag);
    logic [31:0] er;
    logic        eo;
    int          el;
    int          lat;
    model(d, s, data, er, eo, el);
    @(negedge clk);
    drive(d, 1'b1, s, data);
    @(negedge clk);
    drive(d, 1'b0, s, data);
    check({tag, "_busy"}, 32'(dut_busy(d)), 32'd1);
    lat = 0;
    while (!dut_valid(d) && lat < 400) begin
      if (noise) drive(d, 1'($urandom_range(0, 1)), 3'($urandom), 48'({$urandom, $urandom}));
      @(negedge clk);
      lat++;
    end
    drive(d, 1'b0, s, data);
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_out"}, dut_out(d), er);
    check({tag, "_ovf"}, 32'(dut_ovf(d)), 32'(eo));
    check({tag, "_idle"}, 32'(dut_busy(d)), 32'd0);
    $display("txn %s dut=%0d sel=%0d lat=%0d out=%0h ovf=%0b", tag, d, s, lat, dut_out(d), dut_ovf(d));
    @(negedge clk);
    check({tag, "_single"}, 32'(dut_valid(d)), 32'd0);
    check({tag, "_nostart"}, 32'(dut_busy(d)), 32'd0);
  endtask

  initial begin
    logic [47:0] data;
    int          pulses;
    int          seen;
    rst = 1'b1;
    drive(0, 1'b0, 3'd0, 48'd0);
    drive(1, 1'b0, 3'd0, 48'd0);
    repeat (3) @(negedge clk);
    check("rst_a_out", 32'(a_out), 32'd0);
    check("rst_a_ovf", 32'(a_ovf), 32'd0);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_out", 32'(b_out), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;

    // Directed cases.
    txn(0, 3'd3, {12'd125, 12'd0, 12'd0, 12'd0}, 1'b0, "conv125");
    txn(0, 3'd1, {12'd0, 12'd0, 12'hABC, 12'd0}, 1'b0, "raw_ch1");
    txn(0, 3'd5, {12'd125, 12'h123, 12'hABC, 12'h456}, 1'b0, "blank5");
    txn(0, 3'd3, {12'd4095, 36'd0}, 1'b1, "conv4095");
    txn(0, 3'd3, {12'd0, 36'd0}, 1'b0, "conv_zero");
    txn(0, 3'd3, {12'd60, 36'd0}, 1'b0, "conv60");
    txn(1, 3'd3, {12'd4095, 36'd0}, 1'b1, "b_sat");
    txn(1, 3'd3, {12'd59, 36'd0}, 1'b0, "b_59");
    txn(1, 3'd3, {12'd3839, 36'd0}, 1'b0, "b_edge_nosat");
    txn(1, 3'd3, {12'd3840, 36'd0}, 1'b0, "b_edge_sat");

    // Abort a long conversion with reset.
    @(negedge clk);
    drive(0, 1'b1, 3'd3, {12'd4095, 36'd0});
    @(negedge clk);
    drive(0, 1'b0, 3'd3, {12'd4095, 36'd0});
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out", 32'(a_out), 32'd0);
    check("abort_ovf", 32'(a_ovf), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_valid", 32'(a_valid), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_valid) seen++;
    end
    check("abort_nopulse", 32'(seen), 32'd0);
    txn(0, 3'd3, {12'd4095, 36'd0}, 1'b0, "after_abort");

    // Start held high: a new conversion is accepted in every out_valid cycle.
    @(negedge clk);
    drive(0, 1'b1, 3'd3, {12'd125, 36'd0});
    @(negedge clk);
    pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (a_valid) begin
        check("b2b_time", 32'(j), 32'(3 + 4 * pulses));
        check("b2b_out", 32'(a_out), 32'h085);
        pulses++;
      end
    end
    check("b2b_count", 32'(pulses), 32'd5);
    drive(0, 1'b0, 3'd3, {12'd125, 36'd0});
    repeat (6) @(negedge clk);

    // Random transactions on both instances.
    for (int n = 0; n < 40; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      data = 48'({$urandom, $urandom});
      case ($urandom_range(0, 3))
        0: data[47:36] = 12'($urandom_range(0, 180));
        1: data[47:36] = 12'($urandom_range(3700, 4095));
        default: ;
      endcase
      txn(d, 3'($urandom_range(0, 7)), data, 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_time_sel.md
# disp_time_sel

Parametrised, sequential successor to the display source selector. Picks one of `NCH` time sources on request; sources flagged as "seconds" are converted to a packed minutes:seconds word by an iterative divide-by-60. Registered output, start/valid handshake. Sits between timer/stopwatch/memory blocks and the 7-segment decoder.

## Interface
- `NCH`, 4: number of input channels
- `W`, 12: width of each channel value
- `MIN_W`, 7: width of the minutes field of converted output
- `CONV_MASK`, 4'b1000: bit i = 1 → channel i is seconds, convert; 0 → pass raw
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `ch_data`  in  NCH*W  packed channel values, channel i at [i*W +: W]
- `sel`  in  $clog2(NCH)+1  channel select; values ≥ NCH select blank
- `start`  in  1  request: sample `sel` and the selected channel
- `busy`  out  1  conversion in progress; `start` ignored while high
- `out_valid`  out  1  one-cycle pulse: `disp_out` just updated
- `disp_out`  out  MIN_W+6  result; held until next result
- `overflow`  out  1  last result saturated; held with `disp_out`

## Operation
- OUT_W = MIN_W+6. Converted format: {min[MIN_W-1:0], sec[5:0]}, sec 0..59.
- States IDLE, PASS, DIV.
- IDLE, `start`=1: latch `sel`, value v = selected channel.
  - sel ≥ NCH → PASS, result 0.
  - CONV_MASK[sel]=0 → PASS, result = v zero-extended/truncated to OUT_W.
  - CONV_MASK[sel]=1 → DIV, rem ← v, quo ← 0.
- PASS: write result, `overflow` ← 0, pulse `out_valid`, → IDLE.
- DIV, each cycle:
  - rem ≥ 60 and quo < 2^MIN_W−1: rem ← rem−60, quo ← quo+1.
  - rem ≥ 60 and quo = 2^MIN_W−1: write {all-ones, 6'd59}, `overflow` ← 1, pulse, → IDLE.
  - rem < 60: write {quo, rem[5:0]}, `overflow` ← 0, pulse, → IDLE.
- `busy` = (state ≠ IDLE). `start` during PASS/DIV dropped, not queued.
- Channel data changes after sampling do not affect the result in flight.

## Timing
- Reset values: state IDLE, `busy` 0, `out_valid` 0, `disp_out` 0, `overflow` 0, rem/quo 0.
- `start` sampled at edge k → `busy` high after k.
- PASS: result and `out_valid` after edge k+1 (latency 1).
- DIV, q = floor(v/60) without saturation: subtractions on edges k+1..k+q, result/pulse after edge k+q+1 (latency q+1). Saturated: latency 2^MIN_W.
- `busy` falls on the same edge `out_valid` rises; `start` in the `out_valid` cycle is accepted.
- `out_valid` exactly one cycle per accepted `start`.
- `rst` mid-operation: abort, all reset values after that edge, no `out_valid`.
- v = 0 on converted channel: latency 1, result 0.

## Structure
- Package `disp_pkg`: state enum (IDLE, PASS, DIV), `SEC_PER_MIN` = 60, `SEC_W` = 6.
- Sub-module `sec_to_minsec`: iterative divider (rem/quo registers, load, done, sat flag), parametrised by W and MIN_W; top holds select, FSM, output regs.

## Test plan
- Defaults, ch3 = 125, sel = 3, start → `out_valid` 3 cycles later (edge k+3), `disp_out` = 13'h085 (2 min, 5 s), `overflow` 0.
- ch1 = 12'hABC, sel = 1 → next edge `disp_out` = 13'h0ABC; sel = 5 → `disp_out` = 0; both latency 1.
- ch3 = 4095, sel = 3 → latency 69, `disp_out` = {68, 15} = 13'h110F; `start` pulses during busy produce no extra `out_valid`.
- MIN_W = 6, ch3 = 4095 → latency 64, `disp_out` = {63, 59} = 12'hFFB, `overflow` 1; then ch3 = 59 → 12'h03B, `overflow` 0.
- `rst` high at cycle 10 of a 68-iteration conversion → all outputs reset next edge, no `out_valid`; fresh `start` afterwards completes normally.
- Back-to-back: `start` held high continuously → new conversion accepted in each `out_valid` cycle, one pulse per result.
